freq_gate_counter: RTL and testbench

FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

---
 rtl/freq_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 97 +++++++++
 rtl/freq_gate_counter.sv | 97 +++++++++
 tb/tb_freq_gate_counter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared constants for the gated frequency counter.
// Holds the default counter/BCD widths, the BCD converter state encoding
// and the per-digit add-3 helper used by the double-dabble converter.
package freq_pkg;

   localparam int unsigned CNT_W_DEF  = 26;
   localparam int unsigned DIGITS_DEF = 8;

   // Converter state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // Double-dabble digit correction: add 3 to any digit of 5 or more before shifting
   function automatic logic [3:0] dabble_adj(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      load bin and (re)start a conversion; aborts one in flight
//   bin        binary value sampled on start
//   bcd        BCD result, updated only when a conversion completes
//   busy       1 while shifting or finishing
//   done       one-cycle pulse coincident with a bcd update
module bin2bcd_seq
   import freq_pkg::*;
#(
   parameter int unsigned BIN_W  = CNT_W_DEF,
   parameter int unsigned DIGITS = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned SC_W  = $clog2(BIN_W + 1);

   logic [1:0]       state,     state_n;
   logic [BIN_W-1:0] bin_sh,    bin_sh_n;
   logic [BCD_W-1:0] bcd_sh,    bcd_sh_n;
   logic [SC_W-1:0]  shift_cnt, shift_cnt_n;
   logic [BCD_W-1:0] bcd_n;
   logic             busy_n;
   logic             done_n;
   logic [BCD_W-1:0] bcd_adj;

   // Next-state and output logic; start wins over any state so a new value restarts cleanly
   always_comb begin
      state_n     = state;
      bin_sh_n    = bin_sh;
      bcd_sh_n    = bcd_sh;
      shift_cnt_n = shift_cnt;
      bcd_n       = bcd;
      done_n      = 1'b0;
      bcd_adj     = '0;

      for (int i = 0; i < int'(DIGITS); i++) begin
         bcd_adj[4*i +: 4] = dabble_adj(bcd_sh[4*i +: 4]);
      end

      if (start) begin
         state_n     = ST_SHIFT;
         bin_sh_n    = bin;
         bcd_sh_n    = '0;
         shift_cnt_n = '0;
      end else begin
         case (state)
            ST_SHIFT: begin
               {bcd_sh_n, bin_sh_n} = {bcd_adj, bin_sh} << 1;
               shift_cnt_n = shift_cnt + SC_W'(1);
               if (shift_cnt == SC_W'(BIN_W - 1)) begin
                  state_n = ST_DONE;
               end
            end
            ST_DONE: begin
               bcd_n   = bcd_sh;
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
         endcase
      end

      busy_n = (state_n != ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         bin_sh    <= '0;
         bcd_sh    <= '0;
         shift_cnt <= '0;
         bcd       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         bin_sh    <= bin_sh_n;
         bcd_sh    <= bcd_sh_n;
         shift_cnt <= shift_cnt_n;
         bcd       <= bcd_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

endmodule

// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts rising edges of iSig between iTick gate
// pulses and presents the last complete window in binary and BCD.
// Ports:
//   iClk, irst  clock and synchronous active-high reset
//   iTick       one-cycle gate pulse closing one window and opening the next
//   iSig        measured signal, asynchronous to iClk
//   oCount      edge count of the last window (saturating)
//   oOvf        last window saturated
//   oBcd        BCD form of oCount, MS digit in the top nibble
//   oValid      one-cycle pulse when oBcd updates
//   oBusy       BCD conversion in progress
// 4*DIGITS must be wide enough to hold 2^CNT_W-1 in decimal.
module freq_gate_counter
   import freq_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned DIGITS = DIGITS_DEF
) (
   input  logic                  iClk,
   input  logic                  irst,
   input  logic                  iTick,
   input  logic                  iSig,
   output logic [CNT_W-1:0]      oCount,
   output logic                  oOvf,
   output logic [4*DIGITS-1:0]   oBcd,
   output logic                  oValid,
   output logic                  oBusy
);

   logic             sync1;
   logic             sync2;
   logic             prev;
   logic             rise;
   logic [CNT_W-1:0] cnt;
   logic             win_ovf;
   logic             first_tick;
   logic             cnt_max;
   logic [CNT_W-1:0] closing_cnt;
   logic             closing_ovf;
   logic             conv_start;

   assign rise    = sync2 & ~prev;
   assign cnt_max = &cnt;

   // Value of the window being closed, including an edge landing on the tick cycle
   assign closing_cnt = cnt_max ? cnt : (cnt + CNT_W'(rise));
   assign closing_ovf = win_ovf | (cnt_max & rise);

   // The window closed by the first tick after reset is partial, so it is not converted
   assign conv_start = iTick & ~first_tick;

   // Synchronizer, edge register, window counter and result latch
   always_ff @(posedge iClk) begin
      if (irst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         prev       <= 1'b0;
         cnt        <= '0;
         win_ovf    <= 1'b0;
         oCount     <= '0;
         oOvf       <= 1'b0;
         first_tick <= 1'b1;
      end else begin
         sync1 <= iSig;
         sync2 <= sync1;
         prev  <= sync2;
         if (iTick) begin
            oCount     <= closing_cnt;
            oOvf       <= closing_ovf;
            cnt        <= '0;
            win_ovf    <= 1'b0;
            first_tick <= 1'b0;
         end else if (rise) begin
            if (cnt_max) begin
               win_ovf <= 1'b1;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

   // BCD converter restarted by every non-first tick
   bin2bcd_seq #(
      .BIN_W  (CNT_W),
      .DIGITS (DIGITS)
   ) u_bcd (
      .clk   (iClk),
      .rst   (irst),
      .start (conv_start),
      .bin   (closing_cnt),
      .bcd   (oBcd),
      .busy  (oBusy),
      .done  (oValid)
   );

endmodule

// File: tb/tb_freq_gate_counter.sv
// Self-checking bench for freq_gate_counter: two instances (CNT_W=26 and
// CNT_W=4) share stimulus and are compared every cycle against a window-level
// reference model, plus directed table rows and corner sequences.
module tb_freq_gate_counter;

   logic clk = 1'b0;
   always #10 clk = ~clk;

   logic rst, tick, sig;

   logic [25:0] count0;
   logic        ovf0, valid0, busy0;
   logic [31:0] bcd0;
   logic [3:0]  count1;
   logic        ovf1, valid1, busy1;
   logic [7:0]  bcd1;

   freq_gate_counter #(.CNT_W(26), .DIGITS(8)) dut0 (
      .iClk(clk), .irst(rst), .iTick(tick), .iSig(sig),
      .oCount(count0), .oOvf(ovf0), .oBcd(bcd0), .oValid(valid0), .oBusy(busy0)
   );

   freq_gate_counter #(.CNT_W(4), .DIGITS(2)) dut1 (
      .iClk(clk), .iSig(sig), .iTick(tick), .irst(rst),
      .oCount(count1), .oOvf(ovf1), .oBcd(bcd1), .oValid(valid1), .oBusy(busy1)
   );

   int checks;
   int errors;

   // Stimulus generator controls
   int   mode;      // 0 random, 1 periodic, 2 manual level
   int   period;
   int   dens;
   logic man_sig;
   longint scyc;

   // Reference model state: pin history plus per-instance window bookkeeping
   logic   samp[$];
   longint cyc;
   int     wid[2] = '{26, 4};
   int     dig[2] = '{8, 2};
   longint n_edges[2];
   longint exp_count[2];
   logic   exp_ovf[2];
   logic [31:0] exp_bcd[2];
   logic   exp_valid[2];
   logic   exp_busy[2];
   logic   first[2];
   longint conv_val[2];
   longint done_at[2];

   function automatic logic [31:0] to_bcd(input longint v, input int digits);
      logic [31:0] r;
      longint x;
      r = '0;
      x = v;
      for (int i = 0; i < digits; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_edge();
      logic   e;
      longint mx, total;
      cyc++;
      if (rst) begin
         samp.delete();
         repeat (3) samp.push_back(1'b0);
         for (int k = 0; k < 2; k++) begin
            n_edges[k] = 0; exp_count[k] = 0; exp_ovf[k] = 1'b0; exp_bcd[k] = '0;
            exp_valid[k] = 1'b0; exp_busy[k] = 1'b0; first[k] = 1'b1;
            conv_val[k] = 0; done_at[k] = -1;
         end
      end else begin
         // a pin rise is seen by the counter three sampling edges later
         e = samp[1] & ~samp[2];
         samp.push_front(sig);
         void'(samp.pop_back());
         for (int k = 0; k < 2; k++) begin
            mx = (longint'(1) << wid[k]) - 1;
            exp_valid[k] = 1'b0;
            if (tick) begin
               total = n_edges[k] + longint'(e);
               exp_count[k] = (total > mx) ? mx : total;
               exp_ovf[k] = (total > mx);
               n_edges[k] = 0;
               if (first[k]) begin
                  first[k] = 1'b0;
               end else begin
                  conv_val[k] = exp_count[k];
                  done_at[k] = cyc + wid[k] + 1;
               end
            end else begin
               n_edges[k] = n_edges[k] + longint'(e);
            end
            if (cyc == done_at[k]) begin
               exp_valid[k] = 1'b1;
               exp_bcd[k] = to_bcd(conv_val[k], dig[k]);
               done_at[k] = -1;
            end
            exp_busy[k] = (done_at[k] != -1);
         end
      end
   endtask

   task automatic check_dut(input int k, input longint c, input logic o,
                            input logic [31:0] b, input logic v, input logic bz);
      checks++;
      if (c != exp_count[k] || o != exp_ovf[k] || b != exp_bcd[k] ||
          v != exp_valid[k] || bz != exp_busy[k]) begin
         errors++;
         $display("FAIL model_dut%0d cyc %0d: got cnt=%0d ovf=%b bcd=%h valid=%b busy=%b want cnt=%0d ovf=%b bcd=%h valid=%b busy=%b",
                  k, cyc, c, o, b, v, bz, exp_count[k], exp_ovf[k], exp_bcd[k], exp_valid[k], exp_busy[k]);
      end
   endtask

   task automatic expect_eq(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic gen_sig();
      case (mode)
         0:       return ($urandom_range(0, 99) < dens);
         1:       return ((scyc % period) < (period / 2));
         default: return man_sig;
      endcase
   endfunction

   // One clock: drive inputs, advance model on the edge, compare on the falling edge
   task automatic step(input logic t);
      tick = t;
      sig  = gen_sig();
      scyc++;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_dut(0, longint'(count0), ovf0, bcd0, valid0, busy0);
      check_dut(1, longint'(count1), ovf1, {24'h0, bcd1}, valid1, busy1);
   endtask

   task automatic wait_valid(input int which, input int limit, output int lat, output int pulses);
      lat = -1;
      pulses = 0;
      for (int k = 1; k <= limit; k++) begin
         step(1'b0);
         if ((which == 0) ? valid0 : valid1) begin
            pulses++;
            if (lat < 0) lat = k;
         end
      end
   endtask

   typedef struct {
      int          mode;
      int          period;
      logic        lvl;
      int          win;
      longint      count;
      logic [31:0] bcd;
   } row_t;

   row_t rows[6];

   initial begin
      int lat, pulses;
      logic saw_valid, saw_busy;
      logic [10:0] pat;

      rows[0] = '{1, 4,  1'b0, 1000, 250, 32'h0000_0250};
      rows[1] = '{1, 10, 1'b0, 1000, 100, 32'h0000_0100};
      rows[2] = '{1, 8,  1'b0, 1000, 125, 32'h0000_0125};
      rows[3] = '{1, 2,  1'b0, 1000, 500, 32'h0000_0500};
      rows[4] = '{2, 1,  1'b1, 500,  0,   32'h0000_0000};
      rows[5] = '{1, 6,  1'b0, 996,  166, 32'h0000_0166};

      checks = 0; errors = 0; cyc = 0; scyc = 0;
      mode = 2; period = 4; dens = 50; man_sig = 1'b0;
      rst = 1'b1; tick = 1'b0; sig = 1'b0;

      // Reset state
      repeat (3) step(1'b0);
      expect_eq("rst_count", longint'(count0), 0);
      expect_eq("rst_bcd",   longint'(bcd0), 0);
      expect_eq("rst_valid", longint'(valid0), 0);
      expect_eq("rst_busy",  longint'(busy0), 0);

      // First tick closes a partial window without converting
      rst = 1'b0; mode = 1; period = 4;
      repeat (496) step(1'b0);
      step(1'b1);
      expect_eq("first_count_nonzero", longint'(count0 != 0), 1);
      saw_valid = 1'b0; saw_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0);
         saw_valid |= valid0 | valid1;
         saw_busy  |= busy0 | busy1;
      end
      expect_eq("first_no_valid", longint'(saw_valid), 0);
      expect_eq("first_no_busy",  longint'(saw_busy), 0);

      // Full 1000-cycle window at period 4
      repeat (959) step(1'b0);
      step(1'b1);
      expect_eq("w1_count", longint'(count0), 250);
      expect_eq("w1_ovf",   longint'(ovf0), 0);
      wait_valid(0, 40, lat, pulses);
      expect_eq("w1_valid_lat", lat, 27);
      expect_eq("w1_valid_pulses", pulses, 1);
      expect_eq("w1_bcd", longint'(bcd0), 32'h0000_0250);

      // Table of steady patterns
      for (int r = 0; r < 6; r++) begin
         mode = rows[r].mode; period = rows[r].period; man_sig = rows[r].lvl;
         repeat (20) step(1'b0);
         step(1'b1);
         repeat (rows[r].win - 1) step(1'b0);
         step(1'b1);
         expect_eq($sformatf("row%0d_count", r), longint'(count0), rows[r].count);
         expect_eq($sformatf("row%0d_ovf", r), longint'(ovf0), 0);
         wait_valid(0, 40, lat, pulses);
         expect_eq($sformatf("row%0d_lat", r), lat, 27);
         expect_eq($sformatf("row%0d_pulses", r), pulses, 1);
         expect_eq($sformatf("row%0d_bcd", r), longint'(bcd0), longint'(rows[r].bcd));
      end

      // Three edges, the third landing on the tick cycle
      mode = 2; man_sig = 1'b0;
      repeat (5) step(1'b0);
      step(1'b1);
      pat = 11'b11000001010;
      for (int i = 0; i < 11; i++) begin
         man_sig = pat[i];
         step(1'b0);
      end
      man_sig = 1'b1;
      step(1'b1);
      expect_eq("three_count0", longint'(count0), 3);
      expect_eq("three_count1", longint'(count1), 3);
      repeat (30) step(1'b0);
      step(1'b1);
      expect_eq("after_three_count", longint'(count0), 0);

      // Saturation on the narrow instance, then recovery
      man_sig = 1'b0;
      repeat (5) step(1'b0);
      step(1'b1);
      for (int i = 0; i < 20; i++) begin
         man_sig = 1'b1; step(1'b0);
         man_sig = 1'b0; step(1'b0);
      end
      repeat (6) step(1'b0);
      step(1'b1);
      expect_eq("sat_count1", longint'(count1), 15);
      expect_eq("sat_ovf1",   longint'(ovf1), 1);
      expect_eq("sat_count0", longint'(count0), 20);
      expect_eq("sat_ovf0",   longint'(ovf0), 0);
      wait_valid(1, 10, lat, pulses);
      expect_eq("sat_lat1", lat, 5);
      expect_eq("sat_bcd1", longint'(bcd1), 8'h15);
      for (int i = 0; i < 2; i++) begin
         man_sig = 1'b1; step(1'b0);
         man_sig = 1'b0; step(1'b0);
      end
      repeat (36) step(1'b0);
      step(1'b1);
      expect_eq("post_sat_count1", longint'(count1), 2);
      expect_eq("post_sat_ovf1",   longint'(ovf1), 0);

      // Reset in the middle of a conversion
      mode = 1; period = 4;
      repeat (40) step(1'b0);
      step(1'b1);
      repeat (10) step(1'b0);
      expect_eq("mid_busy", longint'(busy0), 1);
      rst = 1'b1;
      step(1'b0);
      expect_eq("mid_rst_out0", longint'({count0, ovf0, bcd0, valid0, busy0}), 0);
      expect_eq("mid_rst_out1", longint'({count1, ovf1, bcd1, valid1, busy1}), 0);
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0);
         saw_valid |= valid0;
      end
      expect_eq("mid_rst_no_valid", longint'(saw_valid), 0);
      step(1'b1);
      saw_valid = 1'b0; saw_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1'b0);
         saw_valid |= valid0;
         saw_busy  |= busy0;
      end
      expect_eq("rst_first_no_valid", longint'(saw_valid), 0);
      expect_eq("rst_first_no_busy",  longint'(saw_busy), 0);

      // Randomized traffic: close ticks abort conversions, occasional resets
      mode = 0;
      for (int i = 0; i < 5000; i++) begin
         if ((i % 500) == 0) dens = int'($urandom_range(5, 95));
         rst = ($urandom_range(0, 799) == 0);
         step($urandom_range(0, 49) == 0);
      end
      rst = 1'b0;
      repeat (40) step(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
